// File: rtl/hms_count_if.sv
// Bus bundle for hms_count: tick/enable/load controls with BCD load values in,
// and current HH:MM:SS digits plus status pulses out.
interface hms_count_if;
    logic       tick;
    logic       en;
    logic       load;
    logic [3:0] ld_hour10;
    logic [3:0] ld_hour01;
    logic [3:0] ld_min10;
    logic [3:0] ld_min01;
    logic [3:0] ld_sec10;
    logic [3:0] ld_sec01;
    logic       ld_pm;
    logic [3:0] SEC01;
    logic [3:0] SEC10;
    logic [3:0] MIN01;
    logic [3:0] MIN10;
    logic [3:0] HOUR01;
    logic [3:0] HOUR10;
    logic       pm;
    logic       day_tick;
    logic       load_err;

    modport master (
        output tick, en, load,
        output ld_hour10, ld_hour01, ld_min10, ld_min01, ld_sec10, ld_sec01, ld_pm,
        input  SEC01, SEC10, MIN01, MIN10, HOUR01, HOUR10, pm, day_tick, load_err
    );

    modport slave (
        input  tick, en, load,
        input  ld_hour10, ld_hour01, ld_min10, ld_min01, ld_sec10, ld_sec01, ld_pm,
        output SEC01, SEC10, MIN01, MIN10, HOUR01, HOUR10, pm, day_tick, load_err
    );
endinterface

// File: rtl/hms_count.sv
// BCD HH:MM:SS time-of-day counter with validated parallel load and day-rollover pulse.
// Define HOUR12_EN for 12-hour operation with AM/PM flag (default build is 24-hour).
module hms_count #(
    parameter logic [3:0] RST_HOUR10 = 4'd0,
    parameter logic [3:0] RST_HOUR01 = 4'd0
) (
    input logic       clk,
    input logic       rst,
    hms_count_if.slave bus
);

`ifdef HOUR12_EN
    // 0/0 is not a legal 12-hour value, so it maps to 12 AM
    localparam logic [3:0] RH10 = (RST_HOUR10 == 4'd0 && RST_HOUR01 == 4'd0) ? 4'd1 : RST_HOUR10;
    localparam logic [3:0] RH01 = (RST_HOUR10 == 4'd0 && RST_HOUR01 == 4'd0) ? 4'd2 : RST_HOUR01;
`else
    localparam logic [3:0] RH10 = RST_HOUR10;
    localparam logic [3:0] RH01 = RST_HOUR01;
`endif

    logic [3:0] sec01_q, sec01_d;
    logic [3:0] sec10_q, sec10_d;
    logic [3:0] min01_q, min01_d;
    logic [3:0] min10_q, min10_d;
    logic [3:0] hour01_q, hour01_d;
    logic [3:0] hour10_q, hour10_d;
    logic       day_tick_q, day_tick_d;
    logic       load_err_q, load_err_d;
`ifdef HOUR12_EN
    logic       pm_q, pm_d;
`else
    logic       unused_ld_pm;
    assign unused_ld_pm = bus.ld_pm;
`endif

    logic ms_ok;
    logic hour_ok;
    logic load_ok;

    always_comb begin
        ms_ok = (bus.ld_min10 <= 4'd5) && (bus.ld_min01 <= 4'd9) &&
                (bus.ld_sec10 <= 4'd5) && (bus.ld_sec01 <= 4'd9);
`ifdef HOUR12_EN
        hour_ok = ((bus.ld_hour10 == 4'd0) && (bus.ld_hour01 >= 4'd1) && (bus.ld_hour01 <= 4'd9)) ||
                  ((bus.ld_hour10 == 4'd1) && (bus.ld_hour01 <= 4'd2));
`else
        hour_ok = ((bus.ld_hour10 <= 4'd1) && (bus.ld_hour01 <= 4'd9)) ||
                  ((bus.ld_hour10 == 4'd2) && (bus.ld_hour01 <= 4'd3));
`endif
        load_ok = ms_ok && hour_ok;
    end

    always_comb begin
        sec01_d    = sec01_q;
        sec10_d    = sec10_q;
        min01_d    = min01_q;
        min10_d    = min10_q;
        hour01_d   = hour01_q;
        hour10_d   = hour10_q;
        day_tick_d = 1'b0;
        load_err_d = 1'b0;
`ifdef HOUR12_EN
        pm_d       = pm_q;
`endif
        if (bus.load) begin
            if (load_ok) begin
                sec01_d  = bus.ld_sec01;
                sec10_d  = bus.ld_sec10;
                min01_d  = bus.ld_min01;
                min10_d  = bus.ld_min10;
                hour01_d = bus.ld_hour01;
                hour10_d = bus.ld_hour10;
`ifdef HOUR12_EN
                pm_d     = bus.ld_pm;
`endif
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.tick && bus.en) begin
            // Ripple all carries within one cycle so no illegal digit is ever visible
            if (sec01_q != 4'd9) begin
                sec01_d = sec01_q + 4'd1;
            end else begin
                sec01_d = '0;
                if (sec10_q != 4'd5) begin
                    sec10_d = sec10_q + 4'd1;
                end else begin
                    sec10_d = '0;
                    if (min01_q != 4'd9) begin
                        min01_d = min01_q + 4'd1;
                    end else begin
                        min01_d = '0;
                        if (min10_q != 4'd5) begin
                            min10_d = min10_q + 4'd1;
                        end else begin
                            min10_d = '0;
`ifdef HOUR12_EN
                            if (hour10_q == 4'd1 && hour01_q == 4'd2) begin
                                hour10_d = 4'd0;
                                hour01_d = 4'd1;
                            end else if (hour10_q == 4'd1 && hour01_q == 4'd1) begin
                                hour10_d   = 4'd1;
                                hour01_d   = 4'd2;
                                pm_d       = ~pm_q;
                                day_tick_d = pm_q;
                            end else if (hour01_q == 4'd9) begin
                                hour10_d = hour10_q + 4'd1;
                                hour01_d = '0;
                            end else begin
                                hour01_d = hour01_q + 4'd1;
                            end
`else
                            if (hour10_q == 4'd2 && hour01_q == 4'd3) begin
                                hour10_d   = '0;
                                hour01_d   = '0;
                                day_tick_d = 1'b1;
                            end else if (hour01_q == 4'd9) begin
                                hour10_d = hour10_q + 4'd1;
                                hour01_d = '0;
                            end else begin
                                hour01_d = hour01_q + 4'd1;
                            end
`endif
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec01_q    <= '0;
            sec10_q    <= '0;
            min01_q    <= '0;
            min10_q    <= '0;
            hour01_q   <= RH01;
            hour10_q   <= RH10;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
`ifdef HOUR12_EN
            pm_q       <= 1'b0;
`endif
        end else begin
            sec01_q    <= sec01_d;
            sec10_q    <= sec10_d;
            min01_q    <= min01_d;
            min10_q    <= min10_d;
            hour01_q   <= hour01_d;
            hour10_q   <= hour10_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
`ifdef HOUR12_EN
            pm_q       <= pm_d;
`endif
        end
    end

    assign bus.SEC01    = sec01_q;
    assign bus.SEC10    = sec10_q;
    assign bus.MIN01    = min01_q;
    assign bus.MIN10    = min10_q;
    assign bus.HOUR01   = hour01_q;
    assign bus.HOUR10   = hour10_q;
    assign bus.day_tick = day_tick_q;
    assign bus.load_err = load_err_q;
`ifdef HOUR12_EN
    assign bus.pm       = pm_q;
`else
    assign bus.pm       = 1'b0;
`endif

endmodule
